// File: rtl/i2c_tx_feeder.sv
// i2c_tx_feeder: FIFO-buffered byte sequencer that frames transfers for i2c_tx.
// Optional watchdog abort is enabled by defining I2C_TX_FEEDER_TIMEOUT_EN.
module i2c_tx_feeder #(
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       wr_data,
   input  logic             wr_last,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic             tx,
   output logic [7:0]       data,
   input  logic             data_en,
   input  logic             ack,
   input  logic             ack_en,
   output logic             busy,
   output logic             done,
   output logic             nak,
   output logic             err,
   output logic [CNT_W-1:0] acked
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE, LOAD, SHIFT, WAIT_ACK, FLUSH, DONE
   } state_t;

   state_t           state_q, state_d;
   logic [8:0]       mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [AW:0]      last_cnt_q, last_cnt_d;
   logic [7:0]       data_q, data_d;
   logic             cur_last_q, cur_last_d;
   logic             nak_pend_q, nak_pend_d;
   logic [CNT_W-1:0] acked_q, acked_d;
   logic             de_q, ae_q, ack_q;
   logic             wr_fire, pop, lc_inc, lc_dec;
   logic             de_rise, de_fall, ae_fall;
   logic [8:0]       head;

   assign wr_ready = (cnt_q != FULL);
   assign wr_fire  = wr_valid & wr_ready;
   assign head     = mem_q[rd_ptr_q];
   assign lc_inc   = wr_fire & wr_last;
   assign lc_dec   = pop & head[8];
   assign de_rise  = data_en & ~de_q;
   assign de_fall  = ~data_en & de_q;
   assign ae_fall  = ~ack_en & ae_q;

`ifdef I2C_TX_FEEDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmr_q, tmr_d;
   logic          err_pend_q, err_pend_d;
   logic          timed, tmo;

   assign timed = (state_q == LOAD) || (state_q == SHIFT) ||
                  (state_q == WAIT_ACK);
   assign tmo   = timed && (tmr_q == TW'(TIMEOUT - 1));
   assign err   = (state_q == DONE) & err_pend_q;

   always_comb begin
      tmr_d = '0;
      if (timed && state_d == state_q) tmr_d = tmr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr_q      <= '0;
         err_pend_q <= 1'b0;
      end else begin
         tmr_q      <= tmr_d;
         err_pend_q <= err_pend_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      cur_last_d = cur_last_q;
      nak_pend_d = nak_pend_q;
      acked_d    = acked_q;
      pop        = 1'b0;
`ifdef I2C_TX_FEEDER_TIMEOUT_EN
      err_pend_d = err_pend_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (last_cnt_q != '0) begin
               pop        = 1'b1;
               data_d     = head[7:0];
               cur_last_d = head[8];
               acked_d    = '0;
               nak_pend_d = 1'b0;
`ifdef I2C_TX_FEEDER_TIMEOUT_EN
               err_pend_d = 1'b0;
`endif
               state_d    = LOAD;
            end
         end
         LOAD:  if (de_rise) state_d = SHIFT;
         SHIFT: if (de_fall) state_d = WAIT_ACK;
         WAIT_ACK: begin
            // ack_q holds the slave's answer from the last ack_en cycle
            if (ae_fall && !ack_q) begin
               if (acked_q != {CNT_W{1'b1}}) acked_d = acked_q + 1'b1;
               if (cur_last_q) begin
                  state_d = DONE;
               end else begin
                  pop        = 1'b1;
                  data_d     = head[7:0];
                  cur_last_d = head[8];
                  state_d    = LOAD;
               end
            end else if (ae_fall) begin
               nak_pend_d = cur_last_q;
               state_d    = cur_last_q ? DONE : FLUSH;
            end
         end
         FLUSH: begin
            pop = 1'b1;
            if (head[8]) begin
               nak_pend_d = 1'b1;
               state_d    = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef I2C_TX_FEEDER_TIMEOUT_EN
      if (tmo && state_d == state_q) begin
         state_d    = cur_last_q ? DONE : FLUSH;
         err_pend_d = 1'b1;
         nak_pend_d = 1'b0;
      end
      if (err_pend_q && state_q == FLUSH) nak_pend_d = 1'b0;
`endif
   end

   always_comb begin
      wr_ptr_d   = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d      = cnt_q;
      last_cnt_d = last_cnt_q;
      if (wr_fire && !pop) cnt_d = cnt_q + 1'b1;
      else if (!wr_fire && pop) cnt_d = cnt_q - 1'b1;
      if (lc_inc && !lc_dec) last_cnt_d = last_cnt_q + 1'b1;
      else if (!lc_inc && lc_dec) last_cnt_d = last_cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q] <= {wr_last, wr_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         last_cnt_q <= '0;
         data_q     <= 8'hFF;
         cur_last_q <= 1'b0;
         nak_pend_q <= 1'b0;
         acked_q    <= '0;
         de_q       <= 1'b0;
         ae_q       <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         last_cnt_q <= last_cnt_d;
         data_q     <= data_d;
         cur_last_q <= cur_last_d;
         nak_pend_q <= nak_pend_d;
         acked_q    <= acked_d;
         de_q       <= data_en;
         ae_q       <= ack_en;
         ack_q      <= ack;
      end
   end

   assign busy  = (state_q == LOAD) || (state_q == SHIFT) ||
                  (state_q == WAIT_ACK) || (state_q == FLUSH);
   assign tx    = ~busy;
   assign done  = (state_q == DONE);
   assign nak   = done & nak_pend_q;
   assign data  = data_q;
   assign acked = acked_q;

endmodule
